hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage RV32I core. It generates the per-stage bubble (hold) and flush (clear) strobes that drive the IF/ID/EX/MEM/WB pipeline registers. Handled events, highest priority first:
- data-cache miss stall, with handshake to the cache;
- control redirect (branch/jalr resolved in EX, jal in ID);
- load-use data hazard.
It also keeps a stall-cycle performance counter and a sticky miss-timeout error flag.

Parameters:
MISS_TIMEOUT, 255, MISS-state cycle count at which miss_timeout_err is set.
CNT_W, 16, width of the stall_cycles counter.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
rs1_ID  in  5  source register 1 of the instruction in ID
rs2_ID  in  5  source register 2 of the instruction in ID
rs1_used_ID  in  1  ID instruction reads rs1
rs2_used_ID  in  1  ID instruction reads rs2
rd_EX  in  5  destination register of the instruction in EX
cache_read_en_EX  in  1  EX instruction is a load
jal_ID  in  1  jal decoded in ID
br_taken_EX  in  1  branch resolved taken in EX
jalr_EX  in  1  jalr in EX
cache_miss  in  1  data cache requests a stall (level)
cache_ready  in  1  data cache refill complete (1-cycle pulse)
bubbleF, bubbleD, bubbleE, bubbleM, bubbleW  out  1 each  hold the stage register
flushF, flushD, flushE, flushM, flushW  out  1 each  clear the stage register (ignored by the register while its bubble is 1)
state  out  2  0=RUN, 1=MISS
stall_cycles  out  CNT_W  count of cycles with bubbleF=1, saturating
miss_timeout_err  out  1  sticky; set when a miss lasts MISS_TIMEOUT cycles

Behaviour:
Reset (asynchronous, active-high):
- state=RUN; stall_cycles=0; miss_timeout_err=0; miss cycle counter=0.
- While rst=1, all bubble*=0 and all flush*=1, so every stage register clears.

Output logic:
- All bubble/flush outputs are combinational from state and inputs; state and counters are registered.
- Any output not listed for a case below is 0.

RUN state, evaluated in priority order:
1. cache_miss=1: bubbleF..bubbleW=1, no flushes. Next state = MISS; the miss counter loads 1.
2. Else br_taken_EX or jalr_EX: flushD=1 and flushE=1, squashing the two wrong-path instructions. The PC redirect is handled elsewhere.
3. Else jal_ID: flushD=1.
4. Else load-use: cache_read_en_EX=1, rd_EX!=0, and either (rs1_used_ID and rs1_ID==rd_EX) or (rs2_used_ID and rs2_ID==rd_EX). Response: bubbleF=1, bubbleD=1, flushE=1. This inserts exactly one bubble, because in the next cycle the load has moved to MEM.

MISS state:
- bubbleF..bubbleW=1 every cycle, no flushes. Redirect and load-use conditions are ignored.
- cache_ready=1: next state = RUN. It wins over a simultaneous cache_miss; a miss still asserted is re-evaluated in RUN the next cycle.
- Otherwise the miss counter increments, saturating. When it reaches MISS_TIMEOUT, miss_timeout_err is set and stays 1 until rst. The block stays in MISS; there is no forced exit.
- A branch frozen in EX during the miss is still valid on return to RUN and is handled there by the normal priority.

stall_cycles:
- Increments on every clock edge where bubbleF=1 (load-use or MISS cycles, including the entry cycle).
- Saturates at 2^CNT_W-1; does not wrap.

Reset mid-miss: state returns to RUN immediately; stall_cycles and miss_timeout_err are cleared.

Test Plan:
1. Load-use: load x5 in EX (cache_read_en_EX=1, rd_EX=5) with ID add reading rs1=5 -> exactly one cycle of bubbleF=bubbleD=flushE=1, then all outputs 0; stall_cycles=1. Repeat with rd_EX=0 -> no stall.
2. Taken branch: br_taken_EX=1 for one cycle -> flushD=flushE=1 that cycle, no bubbles; jal_ID=1 alone -> only flushD=1.
3. Cache miss: cache_miss high for 6 cycles with cache_ready pulsed on cycle 6 -> state=MISS cycles 2-6, all five bubbles=1 cycles 1-6, state=RUN on cycle 7; stall_cycles=6.
4. Priority: cache_miss, br_taken_EX and a load-use condition all asserted together -> only bubbles, no flushes; after cache_ready with br_taken_EX still 1 -> flushD=flushE=1 in the first RUN cycle.
5. Timeout: MISS_TIMEOUT=4, miss held 10 cycles -> miss_timeout_err=1 from the 4th MISS cycle onward, still 1 after return to RUN; rst clears it asynchronously.
6. Saturation and reset: CNT_W=3 with a 12-cycle miss -> stall_cycles holds at 7. Asserting rst mid-miss -> state=RUN, all flush*=1 and all bubble*=0 during reset.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: per-stage bubble (hold) and flush (clear) strobes,
// data-cache miss handshake, stall-cycle counter and sticky miss-timeout flag.
module hazard_ctrl #(
    parameter int unsigned MISS_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic [4:0]       rd_EX,
    input  logic             cache_read_en_EX,
    input  logic             jal_ID,
    input  logic             br_taken_EX,
    input  logic             jalr_EX,
    input  logic             cache_miss,
    input  logic             cache_ready,
    output logic             bubbleF,
    output logic             bubbleD,
    output logic             bubbleE,
    output logic             bubbleM,
    output logic             bubbleW,
    output logic             flushF,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             miss_timeout_err
);

    localparam int unsigned MW = (MISS_TIMEOUT < 2) ? 1 : $clog2(MISS_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MISS = 2'd1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [MW-1:0]   miss_cnt_q;
    logic [MW-1:0]   miss_cnt_d;
    logic            load_use;
    logic            redirect;
    logic            err_set;

    assign state = state_q;

    // Load in EX whose destination feeds a source operand of the ID instruction
    assign load_use = cache_read_en_EX && (rd_EX != 5'd0) &&
                      ((rs1_used_ID && (rs1_ID == rd_EX)) ||
                       (rs2_used_ID && (rs2_ID == rd_EX)));

    assign redirect = br_taken_EX || jalr_EX;

    // Next state and stage strobes; reset forces every stage register to clear
    always_comb begin
        state_d    = state_q;
        miss_cnt_d = miss_cnt_q;
        bubbleF    = 1'b0;
        bubbleD    = 1'b0;
        bubbleE    = 1'b0;
        bubbleM    = 1'b0;
        bubbleW    = 1'b0;
        flushF     = 1'b0;
        flushD     = 1'b0;
        flushE     = 1'b0;
        flushM     = 1'b0;
        flushW     = 1'b0;
        if (rst) begin
            flushF = 1'b1;
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (cache_miss) begin
                        {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW} = 5'b11111;
                        state_d    = MISS;
                        miss_cnt_d = MW'(1);
                    end else if (redirect) begin
                        flushD = 1'b1;
                        flushE = 1'b1;
                    end else if (jal_ID) begin
                        flushD = 1'b1;
                    end else if (load_use) begin
                        bubbleF = 1'b1;
                        bubbleD = 1'b1;
                        flushE  = 1'b1;
                    end
                end
                MISS: begin
                    {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW} = 5'b11111;
                    if (cache_ready) begin
                        state_d = RUN;
                    end else if (miss_cnt_q < MW'(MISS_TIMEOUT)) begin
                        miss_cnt_d = miss_cnt_q + MW'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    assign err_set = (state_d == MISS) && (miss_cnt_d >= MW'(MISS_TIMEOUT));

    // State, miss counter, saturating stall counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= RUN;
            miss_cnt_q       <= '0;
            stall_cycles     <= '0;
            miss_timeout_err <= 1'b0;
        end else begin
            state_q    <= state_d;
            miss_cnt_q <= miss_cnt_d;
            if (bubbleF && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (err_set) begin
                miss_timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a default instance and a small one
// (MISS_TIMEOUT=4, CNT_W=3) share stimulus and are checked against a behavioural model.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] rs1_ID, rs2_ID, rd_EX;
    logic       rs1_used_ID, rs2_used_ID, cache_read_en_EX;
    logic       jal_ID, br_taken_EX, jalr_EX, cache_miss, cache_ready;

    wire  [4:0]  bub_a, fl_a, bub_b, fl_b;
    wire  [1:0]  state_a, state_b;
    wire  [15:0] stall_a;
    wire  [2:0]  stall_b;
    wire         err_a, err_b;
    wire  [9:0]  out_a = {bub_a, fl_a};
    wire  [9:0]  out_b = {bub_b, fl_b};

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: k=0 default instance, k=1 small instance
    int TO[2]   = '{255, 4};
    int SMAX[2] = '{65535, 7};
    bit m_miss[2];
    int m_cnt[2];
    int m_stall[2];
    bit m_err[2];

    hazard_ctrl dut_a (
        .clk(clk), .rst(rst), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID), .rd_EX(rd_EX),
        .cache_read_en_EX(cache_read_en_EX), .jal_ID(jal_ID), .br_taken_EX(br_taken_EX),
        .jalr_EX(jalr_EX), .cache_miss(cache_miss), .cache_ready(cache_ready),
        .bubbleF(bub_a[4]), .bubbleD(bub_a[3]), .bubbleE(bub_a[2]), .bubbleM(bub_a[1]),
        .bubbleW(bub_a[0]), .flushF(fl_a[4]), .flushD(fl_a[3]), .flushE(fl_a[2]),
        .flushM(fl_a[1]), .flushW(fl_a[0]), .state(state_a), .stall_cycles(stall_a),
        .miss_timeout_err(err_a)
    );

    hazard_ctrl #(.MISS_TIMEOUT(4), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID), .rd_EX(rd_EX),
        .cache_read_en_EX(cache_read_en_EX), .jal_ID(jal_ID), .br_taken_EX(br_taken_EX),
        .jalr_EX(jalr_EX), .cache_miss(cache_miss), .cache_ready(cache_ready),
        .bubbleF(bub_b[4]), .bubbleD(bub_b[3]), .bubbleE(bub_b[2]), .bubbleM(bub_b[1]),
        .bubbleW(bub_b[0]), .flushF(fl_b[4]), .flushD(fl_b[3]), .flushE(fl_b[2]),
        .flushM(fl_b[1]), .flushW(fl_b[0]), .state(state_b), .stall_cycles(stall_b),
        .miss_timeout_err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] exp_out(int k);
        bit lu;
        lu = cache_read_en_EX && (rd_EX != 0) &&
             ((rs1_used_ID && rs1_ID == rd_EX) || (rs2_used_ID && rs2_ID == rd_EX));
        if (rst)                          return 10'b00000_11111;
        if (m_miss[k] || cache_miss)      return 10'b11111_00000;
        if (br_taken_EX || jalr_EX)       return 10'b00000_01100;
        if (jal_ID)                       return 10'b00000_01000;
        if (lu)                           return 10'b11000_00100;
        return 10'b0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_miss[k] = 0; m_cnt[k] = 0; m_stall[k] = 0; m_err[k] = 0;
        end
    endtask

    task automatic idle();
        rs1_ID = 0; rs2_ID = 0; rd_EX = 0; rs1_used_ID = 0; rs2_used_ID = 0;
        cache_read_en_EX = 0; jal_ID = 0; br_taken_EX = 0; jalr_EX = 0;
        cache_miss = 0; cache_ready = 0;
    endtask

    // Advance one clock and the model with it; returns at the following negedge
    task automatic next_cycle();
        logic [9:0] e[2];
        for (int k = 0; k < 2; k++) e[k] = exp_out(k);
        @(posedge clk);
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (e[k][9] && m_stall[k] < SMAX[k]) m_stall[k]++;
                if (!m_miss[k]) begin
                    if (cache_miss) begin m_miss[k] = 1; m_cnt[k] = 1; end
                end else if (cache_ready) begin
                    m_miss[k] = 0;
                end else if (m_cnt[k] < TO[k]) begin
                    m_cnt[k]++;
                end
                if (m_miss[k] && m_cnt[k] >= TO[k]) m_err[k] = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; idle(); model_reset();
        #1;
        n_tests++;
        if ({out_a, state_a, stall_a, err_a} !== {10'b00000_11111, 2'd0, 16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_a: got out=%b st=%0d stall=%0d err=%b, want out=0000011111 st=0 stall=0 err=0",
                     out_a, state_a, stall_a, err_a);
        end
        n_tests++;
        if ({out_b, state_b, stall_b, err_b} !== {10'b00000_11111, 2'd0, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_b: got out=%b st=%0d stall=%0d err=%b", out_b, state_b, stall_b, err_b);
        end
        next_cycle();
        rst = 0;
        next_cycle();
    endtask

    task automatic test_load_use();
        idle(); cache_read_en_EX = 1; rd_EX = 5; rs1_ID = 5; rs1_used_ID = 1; rs2_ID = 7;
        #1;
        n_tests++;
        if (out_a !== 10'b11000_00100) begin
            n_fail++; $display("FAIL load_use_stall: got %b want 1100000100", out_a);
        end
        next_cycle();
        idle(); rs1_ID = 5; rs1_used_ID = 1;
        #1;
        n_tests++;
        if (out_a !== 10'b0 || stall_a !== 16'd1) begin
            n_fail++; $display("FAIL load_use_after: got out=%b stall=%0d want 0 / 1", out_a, stall_a);
        end
        cache_read_en_EX = 1; rd_EX = 0; rs1_ID = 0; rs2_ID = 0; rs2_used_ID = 1;
        #1;
        n_tests++;
        if (out_a !== 10'b0) begin
            n_fail++; $display("FAIL load_use_x0: got %b want 0", out_a);
        end
        idle(); cache_read_en_EX = 1; rd_EX = 9; rs2_ID = 9; rs2_used_ID = 1;
        #1;
        n_tests++;
        if (out_b !== 10'b11000_00100) begin
            n_fail++; $display("FAIL load_use_rs2: got %b want 1100000100", out_b);
        end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_redirect();
        idle(); br_taken_EX = 1;
        #1;
        n_tests++;
        if (out_a !== 10'b00000_01100) begin
            n_fail++; $display("FAIL branch: got %b want 0000001100", out_a);
        end
        next_cycle();
        idle(); jal_ID = 1;
        #1;
        n_tests++;
        if (out_a !== 10'b00000_01000) begin
            n_fail++; $display("FAIL jal: got %b want 0000001000", out_a);
        end
        next_cycle();
        idle(); jalr_EX = 1; jal_ID = 1; cache_read_en_EX = 1; rd_EX = 3; rs1_ID = 3; rs1_used_ID = 1;
        #1;
        n_tests++;
        if (out_a !== 10'b00000_01100) begin
            n_fail++; $display("FAIL jalr_prio: got %b want 0000001100", out_a);
        end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_miss();
        rst = 1; idle(); model_reset(); next_cycle(); rst = 0;
        for (int c = 1; c <= 6; c++) begin
            cache_miss = 1; cache_ready = (c == 6);
            #1;
            n_tests++;
            if (out_a !== 10'b11111_00000 || state_a !== ((c == 1) ? 2'd0 : 2'd1)) begin
                n_fail++;
                $display("FAIL miss_cycle%0d: got out=%b st=%0d want 1111100000 st=%0d",
                         c, out_a, state_a, (c == 1) ? 0 : 1);
            end
            next_cycle();
        end
        idle();
        #1;
        n_tests++;
        if (state_a !== 2'd0 || out_a !== 10'b0 || stall_a !== 16'd6 || stall_b !== 3'd6) begin
            n_fail++;
            $display("FAIL miss_exit: got st=%0d out=%b stall_a=%0d stall_b=%0d want 0/0/6/6",
                     state_a, out_a, stall_a, stall_b);
        end
        next_cycle();
    endtask

    task automatic test_priority();
        idle(); cache_miss = 1; br_taken_EX = 1;
        cache_read_en_EX = 1; rd_EX = 4; rs1_ID = 4; rs1_used_ID = 1;
        #1;
        n_tests++;
        if (out_a !== 10'b11111_00000) begin
            n_fail++; $display("FAIL prio_miss: got %b want 1111100000", out_a);
        end
        next_cycle();
        cache_miss = 0; cache_ready = 1;
        next_cycle();
        cache_ready = 0; cache_read_en_EX = 0;
        #1;
        n_tests++;
        if (out_a !== 10'b00000_01100 || state_a !== 2'd0) begin
            n_fail++; $display("FAIL prio_branch_after_miss: got out=%b st=%0d want 0000001100 st=0", out_a, state_a);
        end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_timeout_saturation();
        rst = 1; idle(); model_reset(); next_cycle(); rst = 0;
        for (int c = 1; c <= 10; c++) begin
            cache_miss = 1;
            #1;
            n_tests++;
            if (err_b !== (c >= 5) || err_a !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_cycle%0d: got err_b=%b err_a=%b want %b / 0", c, err_b, err_a, c >= 5);
            end
            next_cycle();
        end
        cache_ready = 1;
        next_cycle();
        idle();
        #1;
        n_tests++;
        if (err_b !== 1'b1 || state_b !== 2'd0 || stall_b !== 3'd7 || stall_a !== 16'd11) begin
            n_fail++;
            $display("FAIL timeout_sticky: got err=%b st=%0d stall_b=%0d stall_a=%0d want 1/0/7/11",
                     err_b, state_b, stall_b, stall_a);
        end
        #2 rst = 1; model_reset();
        #1;
        n_tests++;
        if (err_b !== 1'b0 || stall_b !== 3'd0) begin
            n_fail++; $display("FAIL timeout_async_clear: got err=%b stall=%0d want 0/0", err_b, stall_b);
        end
        next_cycle();
        rst = 0;
        next_cycle();
    endtask

    task automatic test_reset_mid_miss();
        idle(); cache_miss = 1;
        for (int c = 0; c < 3; c++) next_cycle();
        #2 rst = 1; model_reset();
        #1;
        n_tests++;
        if (state_a !== 2'd0 || out_a !== 10'b00000_11111 || stall_a !== 16'd0 || out_b !== 10'b00000_11111) begin
            n_fail++;
            $display("FAIL reset_mid_miss: got st=%0d out_a=%b out_b=%b stall=%0d want 0/0000011111/0000011111/0",
                     state_a, out_a, out_b, stall_a);
        end
        next_cycle();
        rst = 0; idle();
        next_cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rs1_ID = 5'($urandom_range(0, 3)); rs2_ID = 5'($urandom_range(0, 3));
            rd_EX  = 5'($urandom_range(0, 3));
            rs1_used_ID = 1'($urandom); rs2_used_ID = 1'($urandom);
            cache_read_en_EX = 1'($urandom);
            jal_ID = ($urandom_range(0, 7) == 0);
            br_taken_EX = ($urandom_range(0, 7) == 0);
            jalr_EX = ($urandom_range(0, 9) == 0);
            cache_miss = ($urandom_range(0, 5) == 0);
            cache_ready = ($urandom_range(0, 6) == 0);
            #1;
            n_tests++;
            if ({out_a, state_a, err_a} !== {exp_out(0), 2'(m_miss[0]), m_err[0]} ||
                stall_a !== 16'(m_stall[0])) begin
                n_fail++;
                $display("FAIL rand_a[%0d]: got out=%b st=%0d err=%b stall=%0d want out=%b st=%0d err=%b stall=%0d",
                         i, out_a, state_a, err_a, stall_a, exp_out(0), m_miss[0], m_err[0], m_stall[0]);
            end
            n_tests++;
            if ({out_b, state_b, err_b} !== {exp_out(1), 2'(m_miss[1]), m_err[1]} ||
                stall_b !== 3'(m_stall[1])) begin
                n_fail++;
                $display("FAIL rand_b[%0d]: got out=%b st=%0d err=%b stall=%0d want out=%b st=%0d err=%b stall=%0d",
                         i, out_b, state_b, err_b, stall_b, exp_out(1), m_miss[1], m_err[1], m_stall[1]);
            end
            next_cycle();
        end
    endtask

    initial begin
        rst = 1; idle(); model_reset();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_redirect();
        test_miss();
        test_priority();
        test_timeout_saturation();
        test_reset_mid_miss();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
